// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: shared types, constants and pixel quantiser for the video capture block
package vga_capture_pkg;

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DRAIN} state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 15;

    function automatic logic [7:0] rgb_to_332(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {r[3:1], g[3:1], b[3:2]};
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// vga_capture_if: bram-style write bus between the capture master and VRAM
interface vga_capture_if;
    import vga_capture_pkg::*;

    logic              sel_o;
    logic              wr_en_o;
    logic [3:0]        wr_mask_o;
    logic [ADDR_W-1:0] address_o;
    logic [31:0]       data_o;
    logic              ack_i;

    modport master(output sel_o, wr_en_o, wr_mask_o, address_o, data_o, input ack_i);
    modport slave(input sel_o, wr_en_o, wr_mask_o, address_o, data_o, output ack_i);

endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through word FIFO holding {addr,data} entries
module capture_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 47
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; a write into a full FIFO is discarded
    always_ff @(posedge clk)
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= (wr_en && !full) ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= (rd_en && !empty) ? rd_ptr + 1'b1 : rd_ptr;
        end

endmodule

// File: rtl/vga_capture.sv
// vga_capture: samples a 12-bit RGB stream, decimates 2:1, packs RGB332 bytes and writes them to VRAM
module vga_capture import vga_capture_pkg::*; #(
    parameter int                H_RES      = 848,
    parameter int                V_RES      = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 8,
    parameter logic              HS_POL     = 1'b1,
    parameter logic              VS_POL     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic              vga_hsync_i,
    input  logic              vga_vsync_i,
    input  logic              vga_de_i,
    input  logic [3:0]        vga_r_i,
    input  logic [3:0]        vga_g_i,
    input  logic [3:0]        vga_b_i,
    vga_capture_if.master     bus,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic              short_frame_o
);
    localparam int PW = $clog2(H_RES + 1);
    localparam int LW = $clog2(V_RES + 1);

    state_t            state, state_nxt;
    logic              hs_q, vs_q, vs_d, de_q, de_d;
    logic [3:0]        r_q, g_q, b_q;
    logic [PW-1:0]     px_cnt;
    logic [LW-1:0]     line_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [ADDR_W-1:0] wr_idx, wr_addr;
    logic [7:0]        px_byte;
    logic              frame_start, line_on, de_fall, last_line, keep, push;
    logic              start, set_short, fifo_full, fifo_empty, pop;
    logic [ADDR_W+31:0] fifo_head;

    assign frame_start = vs_q == VS_POL && vs_d != VS_POL;
    assign line_on     = de_q && hs_q != HS_POL;
    assign de_fall     = de_d && !de_q;
    assign last_line   = de_fall && line_cnt == LW'(V_RES - 1);
    assign keep        = state == ACTIVE && !frame_start && line_on && !px_cnt[0]
                         && px_cnt < PW'(H_RES) && !line_cnt[0];
    assign push        = keep && byte_cnt == 2'(WORD_BYTES - 1);
    assign px_byte     = rgb_to_332(r_q, g_q, b_q);
    assign wr_addr     = BASE_ADDR + wr_idx;
    assign pop         = bus.sel_o && bus.ack_i;
    assign busy_o      = state != IDLE;
    assign bus.wr_en_o   = bus.sel_o;
    assign bus.wr_mask_o = 4'hF;

    // Single input register stage plus delayed copies for edge detection
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) {hs_q, vs_q, vs_d, de_q, de_d, r_q, g_q, b_q} <= '0;
        else {hs_q, vs_q, vs_d, de_q, de_d, r_q, g_q, b_q} <=
            {vga_hsync_i, vga_vsync_i, vs_q, vga_de_i, de_q, vga_r_i, vga_g_i, vga_b_i};

    // Capture state register
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) state <= IDLE;
        else state <= state_nxt;

    // Next-state logic; enable only matters outside ACTIVE
    always_comb begin
        state_nxt    = state;
        start        = 1'b0;
        set_short    = 1'b0;
        frame_done_o = 1'b0;
        case (state)
            IDLE:   state_nxt = enable_i ? ARM : IDLE;
            ARM: begin
                start     = enable_i && frame_start;
                state_nxt = !enable_i ? IDLE : frame_start ? ACTIVE : ARM;
            end
            ACTIVE: begin
                set_short = frame_start;
                state_nxt = (frame_start || last_line) ? DRAIN : ACTIVE;
            end
            DRAIN: begin
                frame_done_o = fifo_empty && !bus.sel_o;
                state_nxt    = !frame_done_o ? DRAIN : enable_i ? ARM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel/line counters, byte packing, word index and sticky status flags
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) begin
            px_cnt        <= '0;
            line_cnt      <= '0;
            byte_cnt      <= '0;
            word_buf      <= '0;
            wr_idx        <= '0;
            overflow_o    <= 1'b0;
            short_frame_o <= 1'b0;
        end else begin
            px_cnt        <= !line_on ? '0 : px_cnt == PW'(H_RES) ? px_cnt : px_cnt + 1'b1;
            line_cnt      <= start ? '0 : (state == ACTIVE && de_fall) ? line_cnt + 1'b1 : line_cnt;
            byte_cnt      <= state != ACTIVE ? '0 : keep ? byte_cnt + 1'b1 : byte_cnt;
            word_buf      <= keep ? {px_byte, word_buf[23:8]} : word_buf;
            wr_idx        <= start ? '0 : push ? wr_idx + 1'b1 : wr_idx;
            overflow_o    <= start ? 1'b0 : overflow_o | (push & fifo_full);
            short_frame_o <= start ? 1'b0 : short_frame_o | set_short;
        end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W + 32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n_i),
        .wr_en   (push),
        .wr_data ({wr_addr, px_byte, word_buf}),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    // Bus master: present the FIFO head and hold it until acknowledged
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) begin
            bus.sel_o     <= 1'b0;
            bus.address_o <= '0;
            bus.data_o    <= '0;
        end else if (bus.sel_o) begin
            bus.sel_o <= !bus.ack_i;
        end else if (!fifo_empty) begin
            bus.sel_o                    <= 1'b1;
            {bus.address_o, bus.data_o} <= fifo_head;
        end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench for the video capture block
module tb_vga_capture;

    logic       clk = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       enable_i = 1'b0;
    logic       vga_hsync_i = 1'b0, vga_vsync_i = 1'b0, vga_de_i = 1'b0;
    logic [3:0] vga_r_i = '0, vga_g_i = '0, vga_b_i = '0;
    logic       busy_o, frame_done_o, overflow_o, short_frame_o;

    logic [46:0] exp_q[$];
    int          n_chk = 0, n_pass = 0, fd_cnt = 0;
    bit          ack_en = 1'b0;

    vga_capture_if bus();

    vga_capture #(
        .H_RES      (16),
        .V_RES      (4),
        .BASE_ADDR  (15'h100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .enable_i      (enable_i),
        .vga_hsync_i   (vga_hsync_i),
        .vga_vsync_i   (vga_vsync_i),
        .vga_de_i      (vga_de_i),
        .vga_r_i       (vga_r_i),
        .vga_g_i       (vga_g_i),
        .vga_b_i       (vga_b_i),
        .bus           (bus),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .overflow_o    (overflow_o),
        .short_frame_o (short_frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bus slave and scoreboard monitor, both on the falling edge
    initial begin
        bus.ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done_o) fd_cnt++;
            bus.ack_i = ack_en && bus.sel_o;
            if (bus.sel_o && bus.ack_i) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.address_o, bus.data_o);
                end else begin
                    logic [46:0] e;
                    e = exp_q.pop_front();
                    check("write", {bus.wr_en_o, bus.wr_mask_o, bus.address_o, bus.data_o},
                          {1'b1, 4'hF, e});
                end
            end
        end
    end

    task automatic line(input logic vs, input logic de_on, input bit ramp, input logic [11:0] col);
        for (int n = 0; n < 24; n++) begin
            logic [3:0] nn;
            logic       act;
            nn  = 4'(n);
            act = de_on && n < 16;
            @(posedge clk); #1;
            vga_vsync_i = vs;
            vga_de_i    = act;
            vga_hsync_i = n >= 18 && n < 21;
            {vga_r_i, vga_g_i, vga_b_i} = !act ? 12'h000 : ramp ? {nn, 8'h00} : col;
        end
    endtask

    task automatic frame(input int nl, input bit ramp, input logic [11:0] col);
        line(0, 0, 0, 0);
        line(1, 0, 0, 0);
        line(1, 0, 0, 0);
        line(0, 0, 0, 0);
        for (int i = 0; i < nl; i++) line(0, 1, ramp, col);
        line(0, 0, 0, 0);
    endtask

    task automatic wait_fd(input string name, input int target);
        for (int i = 0; i < 3000 && fd_cnt < target; i++) @(negedge clk);
        check(name, fd_cnt, target);
    endtask

    task automatic expect_words(input int n, input logic [31:0] d0, input logic [31:0] d1);
        for (int i = 0; i < n; i++) exp_q.push_back({15'(15'h100 + i), (i % 2 == 0) ? d0 : d1});
    endtask

    initial begin
        #1;
        check("rst_sel", {bus.sel_o, bus.wr_en_o}, 0);
        check("rst_bus", {bus.address_o, bus.data_o}, 0);
        check("rst_flags", {busy_o, frame_done_o, overflow_o, short_frame_o}, 0);
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;

        // 1: solid red
        enable_i = 1'b1;
        ack_en   = 1'b1;
        expect_words(4, 32'hE0E0E0E0, 32'hE0E0E0E0);
        frame(4, 0, 12'hF00);
        wait_fd("t1_done", 1);
        check("t1_pending", exp_q.size(), 0);
        check("t1_flags", {busy_o, overflow_o, short_frame_o}, 3'b100);

        // 2: red ramp, odd lines carry the same ramp and must be skipped
        expect_words(4, 32'h60402000, 32'hE0C0A080);
        frame(4, 1, 0);
        wait_fd("t2_done", 2);
        check("t2_pending", exp_q.size(), 0);

        // 3: bus stalled for the whole frame, only the first two words fit
        ack_en = 1'b0;
        expect_words(2, 32'h1C1C1C1C, 32'h1C1C1C1C);
        frame(4, 0, 12'h0F0);
        check("t3_overflow", overflow_o, 1);
        check("t3_stalled", {busy_o, 32'(fd_cnt)}, {1'b1, 32'd2});
        ack_en = 1'b1;
        wait_fd("t3_done", 3);
        check("t3_pending", exp_q.size(), 0);
        check("t3_overflow_sticky", overflow_o, 1);

        // 4: vsync after two active lines
        expect_words(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        frame(2, 0, 12'hFFF);
        check("t4_overflow_clr", overflow_o, 0);
        line(1, 0, 0, 0);
        line(0, 0, 0, 0);
        check("t4_short", short_frame_o, 1);
        wait_fd("t4_done", 4);
        check("t4_pending", exp_q.size(), 0);

        // 5: reset while a write is held without ack
        ack_en = 1'b0;
        fork
            frame(4, 0, 12'hF00);
            begin
                for (int i = 0; i < 400 && !bus.sel_o; i++) @(negedge clk);
                check("t5_sel_up", bus.sel_o, 1);
                #2;
                enable_i  = 1'b0;
                reset_n_i = 1'b0;
                #1;
                check("t5_sel_drop", {bus.sel_o, bus.wr_en_o}, 0);
                check("t5_rst_flags", {busy_o, overflow_o, short_frame_o}, 0);
                repeat (3) @(negedge clk);
                reset_n_i = 1'b1;
            end
        join
        ack_en = 1'b1;
        frame(4, 0, 12'hF00);
        check("t5_no_write", {32'(exp_q.size()), 32'(fd_cnt)}, {32'd0, 32'd4});
        check("t5_idle", {busy_o, bus.sel_o}, 0);

        // 6: enable dropped mid-frame
        enable_i = 1'b1;
        expect_words(4, 32'h03030303, 32'h03030303);
        fork
            frame(4, 0, 12'h00F);
            begin
                repeat (120) @(negedge clk);
                enable_i = 1'b0;
            end
        join
        wait_fd("t6_done", 5);
        check("t6_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("t6_idle", busy_o, 0);
        frame(4, 0, 12'h00F);
        check("t6_no_rearm", {32'(fd_cnt), 31'd0, busy_o}, {32'd5, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
